// File: rtl/axi_coeff_pkg.sv
// Shared types and constants for the AXI4-Lite coefficient write front end.
// Holds the FSM state encoding, AXI response codes and coefficient defaults.
package axi_coeff_pkg;

  // Write-path FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RESP = 2'd2
  } coeff_wr_state_e;

  // AXI write response codes
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Coefficient array defaults
  localparam int unsigned NUM_COEFF_DEFAULT = 25;
  localparam int unsigned COEFF_WIDTH       = 16;

endpackage : axi_coeff_pkg

// File: rtl/axi_beat_hold.sv
// Single-entry holding register for one AXI channel beat (AW or W).
// Ports:
//   clk_i, rst_ni    clock, asynchronous active-low reset
//   load_i           handshake completing this cycle; captures data_i
//   clr_i            drops the held beat (takes priority over load_i)
//   data_i           incoming beat payload
//   avail_c_o        a beat is held or arriving this cycle
//   avail_data_c_o   payload of that beat (incoming one if arriving)
module axi_beat_hold #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             clr_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             avail_c_o,
  output logic [WIDTH-1:0] avail_data_c_o
);

  logic             full_q, full_d;
  logic [WIDTH-1:0] data_q, data_d;

  // Next-state: clear wins, otherwise a handshake fills the slot
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (clr_i) begin
      full_d = 1'b0;
    end else if (load_i) begin
      full_d = 1'b1;
      data_d = data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  // Lets the parent decide on a beat in the same cycle it arrives
  assign avail_c_o      = full_q | load_i;
  assign avail_data_c_o = load_i ? data_i : data_q;

endmodule : axi_beat_hold

// File: rtl/axi_lite_coeff_wr_if.sv
// AXI4-Lite slave write-channel front end feeding axi_data2coeff.
// Accepts AW and W beats in any order, issues one single-cycle wr_en strobe
// per completed transaction, then returns the B response. Write-only.
// Optional build macro: COEFF_ADDR_CHECK_EN -- suppresses wr_en and answers
// SLVERR for word addresses at or beyond NUM_COEFF.
// Ports:
//   microblaze_clk, rst_n        clock, asynchronous active-low reset
//   s_axi_aw*/s_axi_w*/s_axi_b*  AXI4-Lite write address, data, response
//   wr_en/wr_addr/wr_data/wr_strb  registered write strobe to the consumer
module axi_lite_coeff_wr_if
  import axi_coeff_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_COEFF  = NUM_COEFF_DEFAULT
) (
  input  logic                    microblaze_clk,
  input  logic                    rst_n,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [2:0]              s_axi_awprot,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [1:0]              s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  output logic [ADDR_WIDTH-1:0]   wr_addr,
  output logic                    wr_en,
  output logic [DATA_WIDTH-1:0]   wr_data,
  output logic [DATA_WIDTH/8-1:0] wr_strb
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned IDX_WIDTH  = ADDR_WIDTH - 2;
  localparam int unsigned WPAY_WIDTH = DATA_WIDTH + STRB_WIDTH;

  coeff_wr_state_e         state_q, state_d;
  logic                    awready_q, awready_d;
  logic                    wready_q, wready_d;
  logic                    bvalid_q, bvalid_d;
  logic [1:0]              bresp_q, bresp_d;
  logic                    wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
  logic [STRB_WIDTH-1:0]   wr_strb_q, wr_strb_d;

  logic                    aw_hs_c, w_hs_c, clr_c;
  logic                    aw_avail_c, w_avail_c;
  logic [IDX_WIDTH-1:0]    aw_idx_c;
  logic [WPAY_WIDTH-1:0]   w_pay_c;
  logic                    in_range_c;
  logic                    unused_c;

  assign aw_hs_c = s_axi_awvalid & awready_q;
  assign w_hs_c  = s_axi_wvalid & wready_q;
  assign clr_c   = (state_q == WR);

  // Address is held as a word index; the byte offset is dropped on capture
  axi_beat_hold #(.WIDTH(IDX_WIDTH)) u_aw_hold (
    .clk_i          (microblaze_clk),
    .rst_ni         (rst_n),
    .load_i         (aw_hs_c),
    .clr_i          (clr_c),
    .data_i         (s_axi_awaddr[ADDR_WIDTH-1:2]),
    .avail_c_o      (aw_avail_c),
    .avail_data_c_o (aw_idx_c)
  );

  axi_beat_hold #(.WIDTH(WPAY_WIDTH)) u_w_hold (
    .clk_i          (microblaze_clk),
    .rst_ni         (rst_n),
    .load_i         (w_hs_c),
    .clr_i          (clr_c),
    .data_i         ({s_axi_wdata, s_axi_wstrb}),
    .avail_c_o      (w_avail_c),
    .avail_data_c_o (w_pay_c)
  );

`ifdef COEFF_ADDR_CHECK_EN
  assign in_range_c = (32'(aw_idx_c) < NUM_COEFF);
  assign unused_c   = ^{s_axi_awprot, s_axi_awaddr[1:0]};
`else
  assign in_range_c = 1'b1;
  assign unused_c   = ^{s_axi_awprot, s_axi_awaddr[1:0], 32'(NUM_COEFF)};
`endif

  // Next-state and registered-output logic
  always_comb begin
    state_d   = state_q;
    bvalid_d  = 1'b0;
    bresp_d   = RESP_OKAY;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    wr_strb_d = wr_strb_q;

    case (state_q)
      IDLE: begin
        // Strobe outputs are loaded here so wr_en is high during WR
        if (aw_avail_c && w_avail_c) begin
          state_d = WR;
          if (in_range_c) begin
            wr_en_d   = 1'b1;
            wr_addr_d = {aw_idx_c, 2'b00};
            wr_data_d = w_pay_c[WPAY_WIDTH-1:STRB_WIDTH];
            wr_strb_d = w_pay_c[STRB_WIDTH-1:0];
          end
        end
      end
      WR: begin
        // A suppressed strobe in WR means the address was out of range
        state_d  = RESP;
        bvalid_d = 1'b1;
        bresp_d  = wr_en_q ? RESP_OKAY : RESP_SLVERR;
      end
      RESP: begin
        if (s_axi_bready) begin
          state_d = IDLE;
        end else begin
          bvalid_d = 1'b1;
          bresp_d  = bresp_q;
        end
      end
      default: state_d = IDLE;
    endcase

    awready_d = (state_d == IDLE) && !aw_avail_c;
    wready_d  = (state_d == IDLE) && !w_avail_c;
  end

  always_ff @(posedge microblaze_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_strb_q <= '0;
    end else begin
      state_q   <= state_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      wr_strb_q <= wr_strb_d;
    end
  end

  assign s_axi_awready = awready_q;
  assign s_axi_wready  = wready_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = bresp_q;
  assign wr_en         = wr_en_q;
  assign wr_addr       = wr_addr_q;
  assign wr_data       = wr_data_q;
  assign wr_strb       = wr_strb_q;

endmodule : axi_lite_coeff_wr_if

// File: tb/tb_axi_lite_coeff_wr_if.sv
// Self-checking bench for axi_lite_coeff_wr_if: a transaction-level model
// predicts every output each cycle, a queue scoreboards the write strobes,
// and a few literal expectations pin the directed scenarios.
module tb_axi_lite_coeff_wr_if;

  logic        microblaze_clk;
  logic        rst_n;
  logic [7:0]  s_axi_awaddr;
  logic [2:0]  s_axi_awprot;
  logic        s_axi_awvalid;
  logic        s_axi_awready;
  logic [31:0] s_axi_wdata;
  logic [3:0]  s_axi_wstrb;
  logic        s_axi_wvalid;
  logic        s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready;
  logic [7:0]  wr_addr;
  logic        wr_en;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;

  axi_lite_coeff_wr_if dut (
    .microblaze_clk (microblaze_clk),
    .rst_n          (rst_n),
    .s_axi_awaddr   (s_axi_awaddr),
    .s_axi_awprot   (s_axi_awprot),
    .s_axi_awvalid  (s_axi_awvalid),
    .s_axi_awready  (s_axi_awready),
    .s_axi_wdata    (s_axi_wdata),
    .s_axi_wstrb    (s_axi_wstrb),
    .s_axi_wvalid   (s_axi_wvalid),
    .s_axi_wready   (s_axi_wready),
    .s_axi_bresp    (s_axi_bresp),
    .s_axi_bvalid   (s_axi_bvalid),
    .s_axi_bready   (s_axi_bready),
    .wr_addr        (wr_addr),
    .wr_en          (wr_en),
    .wr_data        (wr_data),
    .wr_strb        (wr_strb)
  );

  initial microblaze_clk = 1'b0;
  always #5 microblaze_clk = ~microblaze_clk;

  int tests  = 0;
  int failed = 0;
  int cyc    = 0;
  int wr_count = 0;
  int last_wr_cyc = 0;
  int last_bv_cyc = 0;
  logic [7:0]  last_wr_addr = '0;
  logic [31:0] last_wr_data = '0;
  logic [1:0]  last_bresp   = '0;
  logic [43:0] exp_q[$];

  always @(posedge microblaze_clk) cyc++;

  function automatic bit in_range(input logic [7:0] a);
`ifdef COEFF_ADDR_CHECK_EN
    return (int'(a >> 2) < 25);
`else
    return 1'b1;
`endif
  endfunction

  // ---------------- behavioural model ----------------
  bit          m_have_aw, m_have_w;
  logic [7:0]  m_addr;
  logic [31:0] m_data;
  logic [3:0]  m_strb;
  int          m_phase;     // 0 accepting, 1 strobe cycle, 2 responding
  logic [1:0]  m_resp;
  logic        e_awready, e_wready, e_wr_en, e_bvalid;
  logic [1:0]  e_bresp;
  logic [7:0]  e_wr_addr;
  logic [31:0] e_wr_data;
  logic [3:0]  e_wr_strb;

  always @(posedge microblaze_clk or negedge rst_n) begin
    if (!rst_n) begin
      m_have_aw = 0; m_have_w = 0; m_phase = 0; m_resp = 2'b00;
      e_awready = 0; e_wready = 0; e_wr_en = 0; e_bvalid = 0; e_bresp = 0;
      e_wr_addr = 0; e_wr_data = 0; e_wr_strb = 0;
    end else begin
      if (m_phase == 0) begin
        if (s_axi_awvalid && e_awready) begin m_have_aw = 1; m_addr = s_axi_awaddr; end
        if (s_axi_wvalid && e_wready) begin m_have_w = 1; m_data = s_axi_wdata; m_strb = s_axi_wstrb; end
        if (m_have_aw && m_have_w) begin
          m_have_aw = 0; m_have_w = 0; m_phase = 1;
          e_wr_en = in_range(m_addr);
          m_resp  = in_range(m_addr) ? 2'b00 : 2'b10;
          if (e_wr_en) begin
            e_wr_addr = m_addr & 8'hFC; e_wr_data = m_data; e_wr_strb = m_strb;
          end
        end
      end else if (m_phase == 1) begin
        m_phase = 2; e_wr_en = 0; e_bvalid = 1; e_bresp = m_resp;
      end else begin
        if (s_axi_bready) begin m_phase = 0; e_bvalid = 0; e_bresp = 0; end
      end
      e_awready = (m_phase == 0) && !m_have_aw;
      e_wready  = (m_phase == 0) && !m_have_w;
    end
  end

  // ---------------- per-cycle compare + strobe scoreboard ----------------
  always @(negedge microblaze_clk) begin
    if (rst_n) begin
      tests++;
      if ({s_axi_awready, s_axi_wready, wr_en, s_axi_bvalid, s_axi_bresp, wr_addr, wr_data, wr_strb} !==
          {e_awready, e_wready, e_wr_en, e_bvalid, e_bresp, e_wr_addr, e_wr_data, e_wr_strb}) begin
        failed++;
        $display("FAIL cycle_check cyc=%0d got awr=%b wr=%b en=%b bv=%b br=%b a=%h d=%h s=%h, expected awr=%b wr=%b en=%b bv=%b br=%b a=%h d=%h s=%h",
                 cyc, s_axi_awready, s_axi_wready, wr_en, s_axi_bvalid, s_axi_bresp, wr_addr, wr_data, wr_strb,
                 e_awready, e_wready, e_wr_en, e_bvalid, e_bresp, e_wr_addr, e_wr_data, e_wr_strb);
      end
      if (wr_en === 1'b1) begin
        wr_count++;
        last_wr_cyc  = cyc;
        last_wr_addr = wr_addr;
        last_wr_data = wr_data;
        tests++;
        if (exp_q.size() == 0) begin
          failed++;
          $display("FAIL strobe_sb cyc=%0d got unexpected wr_en a=%h d=%h, expected none", cyc, wr_addr, wr_data);
        end else begin
          logic [43:0] e;
          e = exp_q.pop_front();
          if ({wr_addr, wr_data, wr_strb} !== e) begin
            failed++;
            $display("FAIL strobe_sb cyc=%0d got %h, expected %h", cyc, {wr_addr, wr_data, wr_strb}, e);
          end
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge microblaze_clk); #1;
  endtask

  task automatic send_aw(input logic [7:0] a, input int dly);
    bit done;
    done = 0;
    repeat (dly) tick();
    s_axi_awaddr  = a;
    s_axi_awprot  = 3'($urandom_range(0, 7));
    s_axi_awvalid = 1'b1;
    for (int k = 0; k < 100 && !done; k++) begin
      @(negedge microblaze_clk);
      if (s_axi_awready) begin tick(); s_axi_awvalid = 1'b0; done = 1; end
    end
    if (!done) begin
      s_axi_awvalid = 1'b0;
      check("aw_timeout", 32'd0, 32'd1);
    end
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s, input int dly);
    bit done;
    done = 0;
    repeat (dly) tick();
    s_axi_wdata  = d;
    s_axi_wstrb  = s;
    s_axi_wvalid = 1'b1;
    for (int k = 0; k < 100 && !done; k++) begin
      @(negedge microblaze_clk);
      if (s_axi_wready) begin tick(); s_axi_wvalid = 1'b0; done = 1; end
    end
    if (!done) begin
      s_axi_wvalid = 1'b0;
      check("w_timeout", 32'd0, 32'd1);
    end
  endtask

  // Waits for bvalid, holds bready low for bd cycles, then completes
  task automatic finish_b(input int bd);
    bit got;
    got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge microblaze_clk);
      if (s_axi_bvalid) begin got = 1; last_bresp = s_axi_bresp; last_bv_cyc = cyc; end
    end
    if (!got) check("bvalid_timeout", 32'd0, 32'd1);
    if (bd > 0) begin
      repeat (bd) tick();
      s_axi_bready = 1'b1;
    end
    tick();
    s_axi_bready = 1'b0;
  endtask

  task automatic txn(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                     input int awd, input int wd, input int bd);
    if (in_range(a)) exp_q.push_back({a & 8'hFC, d, s});
    s_axi_bready = (bd == 0);
    fork
      send_aw(a, awd);
      send_w(d, s, wd);
    join
    finish_b(bd);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int s0, c0;
    rst_n = 1'b0;
    s_axi_awaddr = '0; s_axi_awprot = '0; s_axi_awvalid = 1'b0;
    s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wvalid = 1'b0; s_axi_bready = 1'b0;
    repeat (3) tick();
    check("reset_outputs", {19'd0, s_axi_awready, s_axi_wready, wr_en, s_axi_bvalid, s_axi_bresp, wr_addr}, 32'd0);
    check("reset_data", wr_data, 32'd0);
    rst_n = 1'b1;
    tick();

    // AW and W together, bready already high
    s0 = cyc;
    txn(8'h08, 32'h0000_000C, 4'hF, 0, 0, 0);
    check("t1_addr", 32'(last_wr_addr), 32'h08);
    check("t1_data", last_wr_data, 32'h0000_000C);
    check("t1_wr_latency", 32'(last_wr_cyc - s0), 32'd1);
    check("t1_b_latency", 32'(last_bv_cyc - s0), 32'd2);
    check("t1_bresp", 32'(last_bresp), 32'd0);

    // W three cycles before AW
    txn(8'h30, 32'hFFFF_FFF6, 4'hF, 3, 0, 0);
    check("t2_addr", 32'(last_wr_addr), 32'h30);
    check("t2_coeff", 32'(last_wr_data[15:0]), 32'h0000_FFF6);

    // bready held low for five cycles
    c0 = wr_count;
    txn(8'h14, 32'h0000_0005, 4'h3, 0, 1, 5);
    check("t3_one_strobe", 32'(wr_count - c0), 32'd1);

    // Second AW behind a held AW is back-pressured
    exp_q.push_back({8'h20, 32'hA5A5_0001, 4'hF});
    send_aw(8'h20, 0);
    s_axi_awaddr = 8'h24; s_axi_awvalid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge microblaze_clk);
      check("t4_awready_low", 32'(s_axi_awready), 32'd0);
    end
    tick();
    s_axi_awvalid = 1'b0;
    s_axi_bready = 1'b1;
    send_w(32'hA5A5_0001, 4'hF, 0);
    finish_b(0);
    check("t4_addr", 32'(last_wr_addr), 32'h20);

    // Zero strobes still produce a write, misaligned address is word-aligned
    txn(8'h1B, 32'h1234_5678, 4'h0, 1, 2, 1);
    check("t5_aligned", 32'(last_wr_addr), 32'h18);

    // 25 back-to-back writes at full throughput
    c0 = wr_count;
    s0 = cyc;
    for (int i = 0; i < 25; i++) txn(8'(4 * i), 32'(i + 10), 4'hF, 0, 0, 0);
    check("t6_count", 32'(wr_count - c0), 32'd25);
    check("t6_cycles", 32'(cyc - s0), 32'd75);
    check("t6_last_addr", 32'(last_wr_addr), 32'h60);
    check("t6_last_data", last_wr_data, 32'd34);

    // Reset in the cycle after an AW-only handshake
    send_aw(8'h10, 0);
    rst_n = 1'b0;
    #1;
    check("t7_async_reset", {19'd0, s_axi_awready, s_axi_wready, wr_en, s_axi_bvalid, s_axi_bresp, wr_addr}, 32'd0);
    check("t7_async_data", {wr_data[27:0], wr_strb}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    c0 = wr_count;
    send_w(32'h0000_BEEF, 4'hF, 0);
    repeat (8) tick();
    check("t7_no_strobe", 32'(wr_count - c0), 32'd0);
    do_reset();

    // Word 25, just beyond the coefficient array
    c0 = wr_count;
    txn(8'h64, 32'h0000_0063, 4'hF, 0, 0, 0);
`ifdef COEFF_ADDR_CHECK_EN
    check("t8_suppressed", 32'(wr_count - c0), 32'd0);
    check("t8_bresp", 32'(last_bresp), 32'd2);
`else
    check("t8_forwarded", 32'(wr_count - c0), 32'd1);
    check("t8_addr", 32'(last_wr_addr), 32'h64);
    check("t8_bresp", 32'(last_bresp), 32'd0);
`endif

    // Randomized ordering, delays, addresses and strobes
    for (int i = 0; i < 40; i++) begin
      logic [3:0] s;
      s = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      txn(8'($urandom_range(0, 255)), $urandom, s,
          $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
    end

    repeat (3) tick();
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by %0t, expected completion", $time);
    $fatal(1);
  end

endmodule : tb_axi_lite_coeff_wr_if

// File: doc/axi_lite_coeff_wr_if.md
Name: axi_lite_coeff_wr_if

Overview:
AXI4-Lite slave write-channel front end, directly upstream of axi_data2coeff.
- Accepts MicroBlaze AW/W beats in any order.
- Emits exactly one single-cycle wr_en/wr_addr/wr_data/wr_strb strobe per completed transaction.
- Returns the B response.
- Read channel is out of scope; the coefficient block is write-only.

Parameters:
- ADDR_WIDTH, 8, AXI address width; wr_addr width.
- DATA_WIDTH, 32, AXI data width; wr_strb width is DATA_WIDTH/8.
- NUM_COEFF, 25, number of valid 32-bit coefficient words; used only by the optional range check.

Ports:
- microblaze_clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- s_axi_awaddr  in  ADDR_WIDTH  write address
- s_axi_awprot  in  3  ignored
- s_axi_awvalid  in  1  AW valid
- s_axi_awready  out  1  AW ready
- s_axi_wdata  in  DATA_WIDTH  write data
- s_axi_wstrb  in  DATA_WIDTH/8  byte strobes
- s_axi_wvalid  in  1  W valid
- s_axi_wready  out  1  W ready
- s_axi_bresp  out  2  write response
- s_axi_bvalid  out  1  B valid
- s_axi_bready  in  1  B ready
- wr_addr  out  ADDR_WIDTH  byte address to axi_data2coeff, word aligned
- wr_en  out  1  one-cycle write strobe
- wr_data  out  DATA_WIDTH  write data
- wr_strb  out  DATA_WIDTH/8  byte strobes

Behaviour:
- Reset (rst_n low, asynchronous): all outputs are 0, FSM goes to IDLE, both holding flags are cleared.
- Reset mid-transaction: held beats are discarded, no wr_en is issued, bvalid drops immediately.
- Internal registers:
  - aw_full flag plus address register.
  - w_full flag plus data and strobe registers.
- FSM states:
  - IDLE:
    - s_axi_awready = !aw_full; s_axi_wready = !w_full.
    - A handshake sets the corresponding flag and captures the beat.
    - AW and W in the same cycle are both accepted.
    - When both flags are set (registered or completing this cycle), next state is WR.
  - WR:
    - Lasts exactly one cycle; both ready outputs are 0.
    - wr_en = 1 with wr_addr = {addr[ADDR_WIDTH-1:2], 2'b00}, wr_data and wr_strb driven from the holding registers.
    - Clears both flags; next state is RESP.
  - RESP:
    - bvalid = 1, bresp = 2'b00 (OKAY); both ready outputs are 0.
    - bvalid holds until bready is sampled high, then next state is IDLE.
    - bready already high on the first RESP cycle completes in that cycle.
- Latency:
  - Last of AW/W handshakes in cycle N → wr_en high in N+1 → bvalid high from N+2.
  - Minimum back-to-back throughput: one transaction per 3 cycles.
- Outputs between strobes:
  - wr_addr, wr_data and wr_strb hold their last values.
  - wr_en is 0 in every state except WR.
- Outstanding transactions: at most one. A second AW beat after a held AW, with W not yet arrived, is back-pressured (awready = 0).
- Misaligned awaddr[1:0] is silently dropped.
- wstrb is passed through unchanged, including 4'b0000. That still produces a wr_en strobe; masking is the consumer's job.

Optional Feature:
COEFF_ADDR_CHECK_EN
- Defined:
  - In WR, if addr[ADDR_WIDTH-1:2] >= NUM_COEFF, wr_en stays 0.
  - RESP then returns bresp = 2'b10 (SLVERR); timing is unchanged.
- Undefined:
  - Every address is forwarded and bresp is always OKAY.
  - Out-of-range handling is left to axi_data2coeff.

Decomposition:
- Package axi_coeff_pkg holds:
  - FSM state encoding: IDLE = 2'd0, WR = 2'd1, RESP = 2'd2.
  - AXI response constants: RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10.
  - NUM_COEFF default value.
  - Coefficient width constant, 16.
- Sub-module axi_beat_hold: one valid/ready holding register, instantiated twice (AW, W), with a clear input driven in WR.

Test Plan:
- AW+W same cycle: awaddr 8'h08, wdata 32'h0000_000C, wstrb 4'hF, bready = 1.
  → wr_en for one cycle with wr_addr 8'h08, wr_data 32'h0C; bvalid one cycle later with bresp 00; axi_data2coeff coeff02 = 12.
- W three cycles before AW (addr 8'h30, data 32'hFFFF_FFF6).
  → wready drops after the W handshake; a single wr_en fires the cycle after AW; coeff22 = -10.
- bready held low for 5 cycles after bvalid.
  → bvalid stays high; awready/wready stay 0; no further wr_en; completes on bready.
- 25 back-to-back writes, i = 0..24, addr 4i, data i+10.
  → exactly 25 wr_en pulses; coeff00 = 10 … coeff44 = 34.
- rst_n pulled low in the cycle after an AW-only handshake.
  → all outputs 0 asynchronously; a subsequent W alone produces no wr_en.
- With COEFF_ADDR_CHECK_EN: write to addr 8'h64 (word 25).
  → no wr_en, bresp 2'b10. Without the macro: wr_en asserted, bresp 00.
